// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter and its priority picker.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY     = 2'd1,
    ARB_ERR_HOLD = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_TIMEOUT_DEFAULT   = 255;
  localparam int unsigned ARB_DAT_WIDTH_DEFAULT = 64;

  // Index width for a master count, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: one-hot winner is the first
// requester after i_last in modulo-MASTERS order.
module wb_rr_arbiter_rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned LW      = idx_width(MASTERS)
) (
  input  logic [MASTERS-1:0] i_req,
  input  logic [LW-1:0]      i_last,
  output logic [MASTERS-1:0] o_gnt_c
);

  logic w_found;

  // Offset 1 is checked first so the previous owner ends up with lowest priority.
  always_comb begin
    o_gnt_c = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= MASTERS; i++) begin
      for (int unsigned j = 0; j < MASTERS; j++) begin
        if (!w_found && i_req[j] && (j == ((32'(i_last) + i) % MASTERS))) begin
          o_gnt_c[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between MASTERS requesters.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out a hung slave.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS   = 2,
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned DAT_WIDTH = ARB_DAT_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT   = ARB_TIMEOUT_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [MASTERS-1:0]             m_stb_i,
  input  logic [MASTERS-1:0]             m_we_i,
  input  logic [MASTERS*ADR_WIDTH-1:0]   m_adr_i,
  input  logic [MASTERS*DAT_WIDTH-1:0]   m_dat_i,
  output logic [DAT_WIDTH-1:0]           m_dat_o,
  output logic [MASTERS-1:0]             m_ack_o,
  output logic [MASTERS-1:0]             m_err_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  output logic [ADR_WIDTH-1:0]           s_adr_o,
  output logic [DAT_WIDTH-1:0]           s_dat_o,
  input  logic [DAT_WIDTH-1:0]           s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  output logic [MASTERS-1:0]             grant_o
);

  localparam int unsigned LW = idx_width(MASTERS);

  if (MASTERS < 2 || MASTERS > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("wb_rr_arbiter: MASTERS must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_e           r_state;
  logic [MASTERS-1:0]   r_grant;
  logic [LW-1:0]        r_last;

  logic [MASTERS-1:0]   w_pick;
  logic [LW-1:0]        w_gidx;
  logic [ADR_WIDTH-1:0] w_adr;
  logic [DAT_WIDTH-1:0] w_dat;
  logic                 w_gstb;
  logic                 w_busy;
  logic                 w_hold;
  logic                 w_timeout;

  wb_rr_arbiter_rr_pick #(
    .MASTERS (MASTERS),
    .LW      (LW)
  ) u_rr_pick (
    .i_req   (m_stb_i),
    .i_last  (r_last),
    .o_gnt_c (w_pick)
  );

  // Granted master's index and payload, selected from the one-hot grant.
  always_comb begin
    w_gidx = '0;
    w_adr  = '0;
    w_dat  = '0;
    for (int unsigned j = 0; j < MASTERS; j++) begin
      if (r_grant[j]) begin
        w_gidx = LW'(j);
        w_adr  = m_adr_i[j*ADR_WIDTH +: ADR_WIDTH];
        w_dat  = m_dat_i[j*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign w_gstb = |(r_grant & m_stb_i);
  assign w_busy = (r_state == ARB_BUSY);
  assign w_hold = (r_state == ARB_ERR_HOLD);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign w_timeout = w_busy && (r_cnt == CW'(TIMEOUT)) && !(s_ack_i || s_err_i);

  // Counts BUSY cycles without a slave response; saturates at TIMEOUT.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (!w_busy) begin
      r_cnt <= '0;
    end else if (!(s_ack_i || s_err_i) && (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Slave side follows the granted master directly so stb falls with the master's stb.
  assign s_stb_o = w_busy && w_gstb && !w_timeout;
  assign s_we_o  = w_busy && |(r_grant & m_we_i);
  assign s_adr_o = w_busy ? w_adr : '0;
  assign s_dat_o = w_busy ? w_dat : '0;
  assign m_dat_o = w_busy ? s_dat_i : '0;
  assign m_ack_o = w_busy ? (r_grant & m_stb_i & {MASTERS{s_ack_i}}) : '0;
  assign m_err_o = (w_busy ? (r_grant & m_stb_i & {MASTERS{s_err_i || w_timeout}}) : '0)
                 | (w_hold ? (r_grant & m_stb_i) : '0);
  assign grant_o = r_grant;

  // Phase FSM: grant on request, release when the granted master drops stb.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= LW'(MASTERS - 1);
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (|m_stb_i) begin
            r_grant <= w_pick;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (!w_gstb) begin
            r_last  <= w_gidx;
            r_grant <= '0;
            r_state <= ARB_IDLE;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= ARB_ERR_HOLD;
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        ARB_ERR_HOLD: begin
          if (!w_gstb) begin
            r_last  <= w_gidx;
            r_grant <= '0;
            r_state <= ARB_IDLE;
          end
        end
`endif
        default: begin
          r_grant <= '0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with a ROM-like slave model and a response scoreboard.
module tb_wb_rr_arbiter;

  localparam int unsigned MASTERS   = 2;
  localparam int unsigned ADR_WIDTH = 16;
  localparam int unsigned DAT_WIDTH = 64;
  localparam int unsigned TIMEOUT   = 4;

  logic                         clk_i = 1'b0;
  logic                         rst_i = 1'b0;
  logic [MASTERS-1:0]           m_stb_i = '0;
  logic [MASTERS-1:0]           m_we_i  = '0;
  logic [MASTERS*ADR_WIDTH-1:0] m_adr_i = '0;
  logic [MASTERS*DAT_WIDTH-1:0] m_dat_i = '0;
  logic [DAT_WIDTH-1:0]         m_dat_o;
  logic [MASTERS-1:0]           m_ack_o;
  logic [MASTERS-1:0]           m_err_o;
  logic                         s_stb_o;
  logic                         s_we_o;
  logic [ADR_WIDTH-1:0]         s_adr_o;
  logic [DAT_WIDTH-1:0]         s_dat_o;
  logic [DAT_WIDTH-1:0]         s_dat_i = '0;
  logic                         s_ack_i = 1'b0;
  logic                         s_err_i = 1'b0;
  logic [MASTERS-1:0]           grant_o;
  logic                         hang = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned m;
    logic        err;
    logic [63:0] dat;
  } exp_t;

  exp_t sb[$];

  wb_rr_arbiter #(
    .MASTERS   (MASTERS),
    .ADR_WIDTH (ADR_WIDTH),
    .DAT_WIDTH (DAT_WIDTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .grant_o (grant_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: return 64'h0280401002000010;
      16'h0008: return 64'h0280800000000e60;
      16'h0010: return 64'h0281000000000060;
      default:  return 64'hfe00000000000000;
    endcase
  endfunction

  // ROM slave: one-cycle registered ack for reads, err for writes.
  always @(posedge clk_i) begin
    s_ack_i <= s_stb_o && !s_we_o && !s_ack_i && !s_err_i && !hang;
    s_err_i <= s_stb_o &&  s_we_o && !s_ack_i && !s_err_i && !hang;
    s_dat_i <= rom(s_adr_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned m, input logic err, input logic [63:0] dat);
    exp_t e;
    e.m = m; e.err = err; e.dat = dat;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic req(input int k, input logic we, input logic [15:0] adr, input logic [63:0] dat);
    m_stb_i[k] = 1'b1;
    m_we_i[k]  = we;
    m_adr_i[k*ADR_WIDTH +: ADR_WIDTH] = adr;
    m_dat_i[k*DAT_WIDTH +: DAT_WIDTH] = dat;
  endtask

  task automatic drop(input int k);
    m_stb_i[k] = 1'b0;
    m_we_i[k]  = 1'b0;
  endtask

  task automatic wait_resp(input int k, input string tag);
    int n = 0;
    while (!(m_ack_o[k] || m_err_o[k]) && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 64'(m_ack_o[k] || m_err_o[k]), 64'd1);
  endtask

  // Scoreboard monitor: each new ack/err edge pops and checks one expected response.
  initial begin
    logic [MASTERS-1:0] prev_ack = '0;
    logic [MASTERS-1:0] prev_err = '0;
    logic [MASTERS-1:0] new_ack;
    logic [MASTERS-1:0] new_err;
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      new_ack  = m_ack_o & ~prev_ack;
      new_err  = m_err_o & ~prev_err;
      prev_ack = m_ack_o;
      prev_err = m_err_o;
      if (|new_ack || |new_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'({new_ack, new_err}), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_ack", 64'(m_ack_o), e.err ? 64'd0 : (64'd1 << e.m));
          chk("resp_err", 64'(m_err_o), e.err ? (64'd1 << e.m) : 64'd0);
          if (!e.err) chk("resp_dat", m_dat_o, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset values
    tick(); tick();
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_s_stb", 64'(s_stb_o), 64'd0);
    chk("rst_s_we",  64'(s_we_o),  64'd0);
    chk("rst_s_adr", 64'(s_adr_o), 64'd0);
    chk("rst_s_dat", s_dat_o,      64'd0);
    chk("rst_m_ack", 64'(m_ack_o), 64'd0);
    chk("rst_m_err", 64'(m_err_o), 64'd0);
    chk("rst_m_dat", m_dat_o,      64'd0);
    rst_i = 1'b1;
    tick();

    // Single read by master 0
    req(0, 1'b0, 16'h0000, 64'd0);
    push(0, 1'b0, 64'h0280401002000010);
    chk("t1_stb_before", 64'(s_stb_o), 64'd0);
    tick();
    chk("t1_stb_lat", 64'(s_stb_o), 64'd1);
    chk("t1_grant",   64'(grant_o), 64'd1);
    chk("t1_adr",     64'(s_adr_o), 64'h0000);
    wait_resp(0, "t1_resp");
    drop(0);
    #1;
    chk("t1_stb_fall",   64'(s_stb_o), 64'd0);
    chk("t1_grant_held", 64'(grant_o), 64'd1);
    tick();
    chk("t1_grant_clr", 64'(grant_o), 64'd0);

    // Reset again so last points at master 1
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();

    // Simultaneous requests: master 0 first, then master 1 after one idle cycle
    req(0, 1'b0, 16'h0008, 64'd0);
    req(1, 1'b0, 16'h0010, 64'd0);
    push(0, 1'b0, 64'h0280800000000e60);
    push(1, 1'b0, 64'h0281000000000060);
    tick();
    chk("t2_grant_m0", 64'(grant_o), 64'd1);
    chk("t2_adr_m0",   64'(s_adr_o), 64'h0008);
    wait_resp(0, "t2_resp_m0");
    drop(0);
    tick();
    chk("t2_gap_grant", 64'(grant_o), 64'd0);
    chk("t2_gap_stb",   64'(s_stb_o), 64'd0);
    tick();
    chk("t2_grant_m1", 64'(grant_o), 64'd2);
    chk("t2_adr_m1",   64'(s_adr_o), 64'h0010);
    wait_resp(1, "t2_resp_m1");
    drop(1);
    tick();

    // Master 1 writes the ROM and gets err
    req(1, 1'b1, 16'h0000, 64'hdeadbeef00001234);
    push(1, 1'b1, 64'd0);
    tick();
    chk("t3_grant", 64'(grant_o), 64'd2);
    chk("t3_we",    64'(s_we_o),  64'd1);
    chk("t3_wdat",  s_dat_o,      64'hdeadbeef00001234);
    wait_resp(1, "t3_resp");
    drop(1);
    tick();

    // Unmapped read
    req(0, 1'b0, 16'h0400, 64'd0);
    push(0, 1'b0, 64'hfe00000000000000);
    tick();
    chk("t4_grant", 64'(grant_o), 64'd1);
    wait_resp(0, "t4_resp");
    drop(0);
    tick();

    // Reset while master 1 holds a hung phase
    hang = 1'b1;
    req(1, 1'b0, 16'h0008, 64'd0);
    tick();
    chk("t5_grant_m1", 64'(grant_o), 64'd2);
    tick();
    chk("t5_pending", 64'(m_ack_o), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("t5_rst_stb",   64'(s_stb_o), 64'd0);
    chk("t5_rst_grant", 64'(grant_o), 64'd0);
    chk("t5_rst_ack",   64'(m_ack_o), 64'd0);
    rst_i = 1'b1;
    drop(1);
    hang = 1'b0;
    tick();
    req(0, 1'b0, 16'h0008, 64'd0);
    req(1, 1'b0, 16'h0010, 64'd0);
    push(0, 1'b0, 64'h0280800000000e60);
    push(1, 1'b0, 64'h0281000000000060);
    tick();
    chk("t5_after_rst_grant", 64'(grant_o), 64'd1);
    wait_resp(0, "t5_resp_m0");
    drop(0);
    tick();
    tick();
    chk("t5_grant_m1_next", 64'(grant_o), 64'd2);
    wait_resp(1, "t5_resp_m1");
    drop(1);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: watchdog errors master 0, then master 1 is served
    hang = 1'b1;
    req(0, 1'b0, 16'h0000, 64'd0);
    req(1, 1'b0, 16'h0008, 64'd0);
    push(0, 1'b1, 64'd0);
    tick();
    chk("t6_grant_m0", 64'(grant_o), 64'd1);
    n = 0;
    while (!m_err_o[0] && n < 20) begin
      tick();
      n++;
    end
    chk("t6_busy_cycles", 64'(n),       64'(TIMEOUT));
    chk("t6_stb_forced",  64'(s_stb_o), 64'd0);
    tick();
    chk("t6_hold_err",   64'(m_err_o), 64'd1);
    chk("t6_hold_stb",   64'(s_stb_o), 64'd0);
    chk("t6_hold_grant", 64'(grant_o), 64'd1);
    hang = 1'b0;
    drop(0);
    tick();
    chk("t6_idle_grant", 64'(grant_o), 64'd0);
    chk("t6_idle_err",   64'(m_err_o), 64'd0);
    push(1, 1'b0, 64'h0280800000000e60);
    tick();
    chk("t6_grant_m1", 64'(grant_o), 64'd2);
    wait_resp(1, "t6_resp_m1");
    drop(1);
    tick();
`else
    // Hung slave without watchdog: grant is held indefinitely
    hang = 1'b1;
    req(0, 1'b0, 16'h0000, 64'd0);
    tick();
    n = 0;
    while (grant_o == 2'b01 && m_err_o == '0 && n < 12) begin
      tick();
      n++;
    end
    chk("t6_hung_cycles", 64'(n),       64'd12);
    chk("t6_hung_grant",  64'(grant_o), 64'd1);
    chk("t6_hung_stb",    64'(s_stb_o), 64'd1);
    push(0, 1'b0, 64'h0280401002000010);
    hang = 1'b0;
    wait_resp(0, "t6_resp_late");
    drop(0);
    tick();
`endif

    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one slave port (the boot ROM or any `WB_SLAVE_PORT_SIGNALS` slave) between MASTERS requesters.
- Typical requesters: the CPU instruction-fetch port and the data load/store port.
- Grant is held for one complete bus phase: from the master's stb rise, through the slave's ack/err, until the master drops stb.

Parameters:
- MASTERS, 2, number of requesting masters (2..8).
- ADR_WIDTH, 16, address width.
- DAT_WIDTH, `DAT_WIDTH (64), data width.
- TIMEOUT, 255, watchdog cycles before a forced error (used only with the optional feature).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-low.
- m_stb_i  in  MASTERS  per-master strobe/request.
- m_we_i  in  MASTERS  per-master write enable.
- m_adr_i  in  MASTERS*ADR_WIDTH  flattened addresses; master k occupies [k*ADR_WIDTH +: ADR_WIDTH].
- m_dat_i  in  MASTERS*DAT_WIDTH  flattened write data.
- m_dat_o  out  DAT_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  MASTERS  per-master ack.
- m_err_o  out  MASTERS  per-master err.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  ADR_WIDTH  slave address.
- s_dat_o  out  DAT_WIDTH  slave write data.
- s_dat_i  in  DAT_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- grant_o  out  MASTERS  one-hot current grant (debug/observability).

Behaviour:
- Reset (rst_i==0 at a posedge):
  - state=IDLE, grant=0, last=MASTERS-1.
  - s_stb_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0.
  - m_ack_o=0, m_err_o=0, m_dat_o=0.
- Reset mid-phase: the grant is dropped at that edge and s_stb_o=0 the same cycle. No ack/err is delivered to the interrupted master.
- States:
  - IDLE:
    - If any m_stb_i is set, pick the first requester after `last`, searching in modulo-MASTERS order. The next edge sets grant one-hot and moves to BUSY.
    - Request-to-s_stb_o latency is 1 cycle.
    - No request: stay in IDLE.
  - BUSY:
    - s_stb_o/s_we_o/s_adr_o/s_dat_o are combinationally muxed from the granted master.
    - m_ack_o[g]=s_ack_i & m_stb_i[g] and m_err_o[g]=s_err_i & m_stb_i[g], where g is the granted master.
    - m_dat_o=s_dat_i. All other masters see ack=err=0.
    - When m_stb_i[g] falls, the next edge sets last=g, clears grant and moves to IDLE. s_stb_o therefore falls the same cycle as m_stb_i[g], which lets the slave end its phase.
- No back-to-back grant:
  - At least one IDLE cycle separates phases, so the slave always sees stb low for ≥1 cycle.
  - Throughput is one phase per (slave latency + 2) cycles at best.
- Simultaneous requests are resolved by round-robin pointer only. A master that just finished has the lowest priority.
- A request that drops before it is granted is ignored; no pending state is kept.
- Masters must hold stb, we, adr and dat stable until they see ack/err. The arbiter does not register them.
- If the granted master drops stb before ack, the phase is aborted: return to IDLE and forward no ack.
- Writes to the ROM produce s_err_i, which is forwarded as m_err_o exactly like ack.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to BUSY and increments every BUSY cycle with no s_ack_i/s_err_i.
  - When it reaches TIMEOUT, m_err_o[g] is asserted, s_stb_o is forced to 0, and the state moves to ERR_HOLD.
  - ERR_HOLD keeps m_err_o[g]=m_stb_i[g] until m_stb_i[g] falls, then returns to IDLE with last=g.
  - A late s_ack_i in ERR_HOLD is ignored.
- Without the macro: no counter and no ERR_HOLD state. A hung slave holds the grant indefinitely.

Decomposition:
- Shared package (config.v / wishbone.v): state encodings ARB_IDLE, ARB_BUSY, ARB_ERR_HOLD, plus the default TIMEOUT constant.
- Sub-module rr_pick:
  - Combinational round-robin priority encoder.
  - Inputs: req[MASTERS-1:0], last index. Output: one-hot winner.
  - Reused later by the interrupt controller.

Test Plan:
- Single master 0 reads ROM adr 0x0000 → s_stb_o rises 1 cycle after m_stb_i[0]; m_ack_o[0]=1 with m_dat_o=64'h0280401002000010; grant clears 1 cycle after m_stb_i[0] drops.
- Masters 0 and 1 request together from reset (last=1) → master 0 is granted first, reading adr 0x0008 = 64'h0280800000000e60. Master 1, held high, is granted next and reads adr 0x0010 = 64'h0281000000000060. Exactly one IDLE cycle lies between the phases.
- Master 1 writes adr 0x0000 → m_err_o[1]=1, m_ack_o[1]=0, master 0 untouched.
- Master 0 reads an unmapped adr 0x0400 → ack with 64'hfe00000000000000.
- rst_i=0 while BUSY with master 1 granted → next cycle: s_stb_o=0, grant_o=0, no ack to master 1, and the next simultaneous request grants master 0.
- With WB_ARB_TIMEOUT_EN, TIMEOUT=4, slave ack tied 0 → m_err_o[0] asserts after 4 BUSY cycles and s_stb_o drops; after m_stb_i[0] falls the state is IDLE and master 1 is granted next.
